// File: rtl/bg_arb_pkg.sv
// Shared types for the background-memory arbiter: default widths, FSM states and the
// command record captured from a requester when it wins arbitration.
package bg_arb_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Sized by the package defaults; overriding the arbiter widths means updating these too.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W_DEF-1:0]   be;
  } cmd_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick with a request mask; on a tie the requester not granted last wins.
// The last-grant register resets to 1 so requester 0 has priority on the first tie.
module rr_pick2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       upd,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  logic       last_q, last_d;
  logic [1:0] cand;

  always_comb begin
    cand    = req & ~mask;
    gnt_vld = |cand;
    gnt_idx = cand[1];
    if (&cand) gnt_idx = ~last_q;
    last_d  = last_q;
    if (upd && gnt_vld) last_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/bg_mem_arbiter.sv
// Arbitrates the display reader (rq0) and game-logic writer (rq1) onto the memory s2 port.
// Registered mem_* outputs: ack/chipselect one cycle after req; read data one cycle after issue.
module bg_mem_arbiter
  import bg_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                rq0_req,
  input  logic                rq0_we,
  input  logic [ADDR_W-1:0]   rq0_addr,
  input  logic [DATA_W-1:0]   rq0_wdata,
  input  logic [DATA_W/8-1:0] rq0_be,
  output logic                rq0_ack,
  output logic                rq0_rvalid,
  output logic [DATA_W-1:0]   rq0_rdata,
  input  logic                rq1_req,
  input  logic                rq1_we,
  input  logic [ADDR_W-1:0]   rq1_addr,
  input  logic [DATA_W-1:0]   rq1_wdata,
  input  logic [DATA_W/8-1:0] rq1_be,
  output logic                rq1_ack,
  output logic                rq1_rvalid,
  output logic [DATA_W-1:0]   rq1_rdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic              clken_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_id_q, rd_id_d;

  logic [1:0] pick_mask;
  logic       pick_upd, pick_vld, pick_idx;
  cmd_t       cmd0, cmd1, sel;

  assign cmd0 = {rq0_we, rq0_addr, rq0_wdata, rq0_be};
  assign cmd1 = {rq1_we, rq1_addr, rq1_wdata, rq1_be};

  rr_pick2 u_pick (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .req     ({rq1_req, rq0_req}),
    .mask    (pick_mask),
    .upd     (pick_upd),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

  // IDLE and ISSUE share the capture path; ISSUE only differs by masking the current grant.
  always_comb begin
    state_d   = ST_IDLE;
    gnt_d     = gnt_q;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    pick_mask = 2'b00;
    pick_upd  = 1'b0;
    rd_pend_d = (state_q == ST_ISSUE) && !we_q;
    rd_id_d   = gnt_q;
    sel       = pick_idx ? cmd1 : cmd0;

    if (state_q == ST_ISSUE) pick_mask = gnt_q ? 2'b10 : 2'b01;

    if (pick_vld) begin
      state_d  = ST_ISSUE;
      gnt_d    = pick_idx;
      pick_upd = 1'b1;
      cs_d     = 1'b1;
      we_d     = sel.we;
      addr_d   = sel.addr;
      wdata_d  = sel.wdata;
      be_d     = sel.we ? sel.be : {BE_W{1'b1}};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      clken_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      clken_q   <= 1'b1;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_clken      = clken_q;
  assign mem_write      = we_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;

  assign rq0_ack    = (state_q == ST_ISSUE) && !gnt_q;
  assign rq1_ack    = (state_q == ST_ISSUE) &&  gnt_q;
  assign rq0_rvalid = rd_pend_q && !rd_id_q;
  assign rq1_rvalid = rd_pend_q &&  rd_id_q;
  assign rq0_rdata  = rq0_rvalid ? mem_readdata : '0;
  assign rq1_rdata  = rq1_rvalid ? mem_readdata : '0;

endmodule

// File: tb/tb_bg_mem_arbiter.sv
// Bench for bg_mem_arbiter: RAM model on the s2 port, table of single accesses,
// hand sequences for alternation, lone-requester pacing, ties and reset during a read.
module tb_bg_mem_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        rq0_req = 1'b0, rq0_we = 1'b0;
  logic [12:0] rq0_addr = '0;
  logic [15:0] rq0_wdata = '0;
  logic [1:0]  rq0_be = '0;
  logic        rq1_req = 1'b0, rq1_we = 1'b0;
  logic [12:0] rq1_addr = '0;
  logic [15:0] rq1_wdata = '0;
  logic [1:0]  rq1_be = '0;
  logic        rq0_ack, rq0_rvalid, rq1_ack, rq1_rvalid;
  logic [15:0] rq0_rdata, rq1_rdata;
  logic [12:0] mem_address;
  logic        mem_chipselect, mem_clken, mem_write;
  logic [15:0] mem_writedata, mem_readdata;
  logic [1:0]  mem_byteenable;

  bg_mem_arbiter dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_be(rq0_be), .rq0_ack(rq0_ack), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_be(rq1_be), .rq1_ack(rq1_ack), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata)
  );

  initial forever #5 clk_clk = ~clk_clk;

  // On-chip RAM with one cycle of read latency and byte-lane writes.
  logic [15:0] ram [0:8191];
  always @(posedge clk_clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
        if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
      end
      mem_readdata <= ram[mem_address];
    end
  end

  typedef struct {
    bit          id;
    bit          we;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [1:0]  exp_be;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          id;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit id, input bit req, input bit we, input logic [12:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be);
    if (!id) begin
      rq0_req = req; rq0_we = we; rq0_addr = addr; rq0_wdata = wdata; rq0_be = be;
    end else begin
      rq1_req = req; rq1_we = we; rq1_addr = addr; rq1_wdata = wdata; rq1_be = be;
    end
  endtask

  function automatic logic ack_of(input bit id);
    return id ? rq1_ack : rq0_ack;
  endfunction

  function automatic logic rvalid_of(input bit id);
    return id ? rq1_rvalid : rq0_rvalid;
  endfunction

  task automatic check_reset();
    chk("rst_ack_rvalid", 32'({rq0_ack, rq1_ack, rq0_rvalid, rq1_rvalid}), 32'h0);
    chk("rst_rdata", 32'({rq0_rdata, rq1_rdata}), 32'h0);
    chk("rst_mem_ctl", 32'({mem_chipselect, mem_clken, mem_write, mem_byteenable}), 32'h0);
    chk("rst_mem_addr", 32'(mem_address), 32'h0);
    chk("rst_mem_wdata", 32'(mem_writedata), 32'h0);
  endtask

  task automatic sb_check(input bit id, input logic [15:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected_rvalid: got rvalid on rq%0d expected none at %0t", id, $time);
    end else begin
      e = sb_q.pop_front();
      chk("sb_rid", 32'(id), 32'(e.id));
      chk("sb_rdata", 32'(data), 32'(e.data));
    end
  endtask

  always @(negedge clk_clk) begin
    if (reset_reset_n === 1'b1) begin
      if (rq0_rvalid) sb_check(1'b0, rq0_rdata);
      else            chk("rdata0_idle", 32'(rq0_rdata), 32'h0);
      if (rq1_rvalid) sb_check(1'b1, rq1_rdata);
      else            chk("rdata1_idle", 32'(rq1_rdata), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];
  vec_t v;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 13'h0123, 16'hBEEF, 2'b11, 2'b11, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 13'h0123, 16'h0000, 2'b00, 2'b11, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 13'h0000, 16'h1234, 2'b11, 2'b11, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 13'h1FFF, 16'hA5C3, 2'b11, 2'b11, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 13'h0000, 16'h0000, 2'b01, 2'b11, 16'h1234};
    vecs[5] = '{1'b0, 1'b0, 13'h1FFF, 16'h0000, 2'b10, 2'b11, 16'hA5C3};
    vecs[6] = '{1'b0, 1'b1, 13'h0040, 16'h1357, 2'b11, 2'b11, 16'h0000};
    vecs[7] = '{1'b1, 1'b1, 13'h0040, 16'hFFFF, 2'b10, 2'b10, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 13'h0040, 16'h0000, 2'b00, 2'b11, 16'hFF57};

    @(negedge clk_clk);
    @(negedge clk_clk);
    check_reset();
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("clken_after_reset", 32'(mem_clken), 32'h1);

    // Single accesses from an idle arbiter.
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      @(negedge clk_clk);
      drive(v.id, 1'b1, v.we, v.addr, v.wdata, v.be);
      @(negedge clk_clk);
      chk("tbl_ack", 32'(ack_of(v.id)), 32'h1);
      chk("tbl_other_ack", 32'(ack_of(!v.id)), 32'h0);
      chk("tbl_cs", 32'(mem_chipselect), 32'h1);
      chk("tbl_addr", 32'(mem_address), 32'(v.addr));
      chk("tbl_write", 32'(mem_write), 32'(v.we));
      chk("tbl_be", 32'(mem_byteenable), 32'(v.exp_be));
      if (v.we) chk("tbl_wdata", 32'(mem_writedata), 32'(v.wdata));
      else      sb_q.push_back('{v.id, v.exp_rdata});
      drive(v.id, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
      @(negedge clk_clk);
      chk("tbl_rvalid", 32'(rvalid_of(v.id)), 32'(!v.we));
      chk("tbl_cs_idle", 32'(mem_chipselect), 32'h0);
    end

    // Both requesters held from reset: grants alternate with chipselect held.
    @(negedge clk_clk);
    reset_reset_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 13'h1FFF, 16'h0000, 2'b00);
    drive(1'b1, 1'b1, 1'b1, 13'h1FFF, 16'h00FF, 2'b01);
    @(negedge clk_clk);
    check_reset();
    reset_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_clk);
      chk("alt_ack0", 32'(rq0_ack), 32'(i % 2 == 0));
      chk("alt_ack1", 32'(rq1_ack), 32'(i % 2 == 1));
      chk("alt_cs", 32'(mem_chipselect), 32'h1);
      chk("alt_addr", 32'(mem_address), 32'h1FFF);
      if (rq0_ack) sb_q.push_back('{1'b0, (i == 0) ? 16'hA5C3 : 16'hA5FF});
      if (i == 4) drive(1'b0, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
      if (i == 5) drive(1'b1, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
    end
    @(negedge clk_clk);
    chk("alt_cs_idle", 32'(mem_chipselect), 32'h0);

    // Lone writer: one ack every second cycle.
    @(negedge clk_clk);
    drive(1'b1, 1'b1, 1'b1, 13'h0050, 16'h5555, 2'b11);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_clk);
      chk("lone_ack1", 32'(rq1_ack), 32'((i % 2 == 0) && (i < 7)));
      chk("lone_cs", 32'(mem_chipselect), 32'((i % 2 == 0) && (i < 7)));
      chk("lone_ack0", 32'(rq0_ack), 32'h0);
      if (i == 6) drive(1'b1, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
    end

    // Tie after last grant to rq1: rq0 first, then rq1.
    drive(1'b0, 1'b1, 1'b1, 13'h0060, 16'h1111, 2'b11);
    drive(1'b1, 1'b1, 1'b1, 13'h0061, 16'h2222, 2'b11);
    @(negedge clk_clk);
    chk("tieA_first_ack0", 32'({rq1_ack, rq0_ack}), 32'b01);
    chk("tieA_first_addr", 32'(mem_address), 32'h0060);
    drive(1'b0, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk_clk);
    chk("tieA_second_ack1", 32'({rq1_ack, rq0_ack}), 32'b10);
    chk("tieA_second_addr", 32'(mem_address), 32'h0061);
    drive(1'b1, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk_clk);

    // Make rq0 the last grant, then tie: rq1 first.
    drive(1'b0, 1'b1, 1'b1, 13'h0062, 16'h3333, 2'b11);
    @(negedge clk_clk);
    chk("tieB_pre_ack0", 32'(rq0_ack), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk_clk);
    drive(1'b0, 1'b1, 1'b1, 13'h0063, 16'h4444, 2'b11);
    drive(1'b1, 1'b1, 1'b1, 13'h0064, 16'h5555, 2'b11);
    @(negedge clk_clk);
    chk("tieB_first_ack1", 32'({rq1_ack, rq0_ack}), 32'b10);
    chk("tieB_first_addr", 32'(mem_address), 32'h0064);
    drive(1'b1, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk_clk);
    chk("tieB_second_ack0", 32'({rq1_ack, rq0_ack}), 32'b01);
    drive(1'b0, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk_clk);

    // Reset right after a read issue: its rvalid is discarded.
    drive(1'b0, 1'b1, 1'b0, 13'h0123, 16'h0, 2'b00);
    @(negedge clk_clk);
    chk("rstrd_ack0", 32'(rq0_ack), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
    @(posedge clk_clk);
    #1 reset_reset_n = 1'b0;
    @(negedge clk_clk);
    check_reset();
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("rstrd_no_rvalid", 32'({rq1_rvalid, rq0_rvalid}), 32'h0);
    chk("rstrd_cs", 32'(mem_chipselect), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 13'h0000, 16'h0, 2'b00);
    @(negedge clk_clk);
    chk("rstrd_next_ack1", 32'(rq1_ack), 32'h1);
    chk("rstrd_next_addr", 32'(mem_address), 32'h0000);
    sb_q.push_back('{1'b1, 16'h1234});
    drive(1'b1, 1'b0, 1'b0, 13'h0, 16'h0, 2'b00);
    @(negedge clk_clk);
    chk("rstrd_next_rvalid1", 32'(rq1_rvalid), 32'h1);
    @(negedge clk_clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bg_mem_arbiter.md
BG_MEM_ARBITER -- requirements
Module: bg_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: word address width of the background memory s2 port.
REQ-002 Parameter DATA_W, default 16: data width; byte-enable width is DATA_W/8.
REQ-003 Port clk_clk, in, 1: single clock for all logic.
REQ-004 Port reset_reset_n, in, 1: reset, asynchronous assert, active-low.
REQ-005 Ports rq0_req / rq1_req, in, 1: access request from requester 0 (LT24 display reader) or requester 1 (game-logic writer).
REQ-006 Ports rqN_we, in, 1: 1 = write, 0 = read.
REQ-007 Ports rqN_addr, in, ADDR_W: word address.
REQ-008 Ports rqN_wdata, in, DATA_W: write data.
REQ-009 Ports rqN_be, in, DATA_W/8: write byte enables.
REQ-010 Ports rqN_ack, out, 1: one-cycle pulse; the access has been issued.
REQ-011 Ports rqN_rvalid, out, 1: one-cycle pulse; rqN_rdata is valid.
REQ-012 Ports rqN_rdata, out, DATA_W: read data.
REQ-013 Ports mem_address (out, ADDR_W), mem_chipselect, mem_clken, mem_write (out, 1), mem_writedata (out, DATA_W), mem_byteenable (out, DATA_W/8), mem_readdata (in, DATA_W): drive the memory s2 port.

Function
REQ-014 Requester holds req, we, addr, wdata and be stable from req assertion until it samples its ack; it may change them in the cycle after ack.
REQ-015 FSM states: IDLE, ISSUE.
REQ-016 IDLE: no req -> stay in IDLE; any req -> register the winner's command and go to ISSUE.
REQ-017 ISSUE: chipselect=1, ack of the granted requester =1 for exactly this cycle.
REQ-018 In ISSUE, the granted requester is masked from arbitration; if the other requester's req=1, its command is registered and the FSM stays in ISSUE; else go to IDLE.
REQ-019 Arbitration is round-robin: on a tie, the requester not granted last wins; after reset, requester 0 has priority.
REQ-020 All mem_* outputs are registered; latency from req rising (FSM in IDLE) to ack/chipselect is 1 cycle.
REQ-021 mem_write=rqN_we and mem_byteenable=rqN_be for writes; for reads, mem_write=0 and mem_byteenable=all ones.
REQ-022 mem_clken=1 whenever out of reset.
REQ-023 Memory read latency is fixed at 1: rqN_rvalid pulses in the cycle after a read ISSUE cycle for that requester; rqN_rdata = mem_readdata combinationally while rvalid=1, and 0 otherwise.
REQ-024 Writes produce no rvalid.
REQ-025 Peak throughput: 1 access/cycle when both requesters are active (alternating); a lone requester gets 1 access per 2 cycles.
REQ-026 Simultaneous reqs with different we are arbitrated identically to same-type requests.
REQ-027 A req that drops before its ack is a protocol violation; no recovery behaviour is defined.

Reset
REQ-028 While reset_reset_n=0: FSM=IDLE, last-grant=1, all ack/rvalid/rdata=0, mem_chipselect=0, mem_write=0, mem_clken=0, mem_address=0, mem_writedata=0, mem_byteenable=0.
REQ-029 A read in flight when reset asserts is discarded; no rvalid follows deassertion.
REQ-030 The first arbitration happens on the first rising edge after reset deassertion.

Structure
REQ-031 Shared package bg_arb_pkg holds ADDR_W/DATA_W defaults, the FSM state enum and the command record type (we, addr, wdata, be).
REQ-032 The 2-way round-robin pick, with mask input and last-grant register, is in one sub-module, rr_pick2; all other logic is in bg_mem_arbiter.

Verification
REQ-033 rq0 read addr 0x0123, mem holds 0xBEEF -> ack0 at cycle+1 with mem_address=0x0123, chipselect=1, write=0, be=2'b11; rvalid0=1 with rdata0=0xBEEF at cycle+2; rvalid1 never asserts.
REQ-034 rq0 and rq1 asserted continuously from reset (rq0 read, rq1 write 0x1FFF/0x00FF, be=2'b01) -> grants alternate 0,1,0,1 on consecutive cycles with chipselect held at 1; readback of 0x1FFF returns the low byte updated.
REQ-035 rq1 alone issues back-to-back writes -> ack1 on every second cycle only; it is never acked in two consecutive cycles.
REQ-036 Tie after the last grant to rq1 -> rq0 wins; tie after the last grant to rq0 -> rq1 wins.
REQ-037 Reset pulsed in the cycle after a read ISSUE -> no rvalid; all outputs at REQ-028 values; the next request is acked 1 cycle after req.
REQ-038 Address 0 and max address 0x1FFF for read and write -> correct mem_address with no wrap-around corruption.
